// File: rtl/edge_ctrl_pkg.sv
// Shared types for the Sobel window sequencer: FSM states, output modes and
// the width of the control bits carried alongside each window coordinate.
package edge_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_MAG  = 2'd0,
        MODE_GX   = 2'd1,
        MODE_GY   = 2'd2,
        MODE_GRAY = 2'd3
    } mode_e;

    // valid, end-of-line, end-of-frame
    localparam int CTRL_BITS = 3;

endpackage

// File: rtl/win_delay_pipe.sv
// Fixed-latency shift register that keeps window metadata aligned with the
// kernel result; flush drops in-flight windows by clearing only the MSB (valid).
module win_delay_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift every cycle; the valid bit is masked while a flush is requested.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= {i_data[WIDTH-1] & ~i_flush, i_data[WIDTH-2:0]};
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= {r_stage[k-1][WIDTH-1] & ~i_flush, r_stage[k-1][WIDTH-2:0]};
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/edge_window_ctrl.sv
// Sequencer for the 3x3 Sobel window: counts pixels per frame, tags interior
// windows with their centre coordinate and delays the tags to kernel latency.
module edge_window_ctrl
    import edge_ctrl_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int LAT   = 2,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iPIX_VAL,
    input  logic          iFRAME_START,
    input  logic [1:0]    iMODE,
    input  logic          iMODE_WR,
    output logic [CW-1:0] oX,
    output logic [RW-1:0] oY,
    output logic          oWIN_VALID,
    output logic [1:0]    oMODE,
    output logic          oLINE_DONE,
    output logic          oFRAME_DONE,
    output logic          oBUSY,
    output logic          oERR
);

    localparam int PW = CTRL_BITS + CW + RW;
    localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [FW-1:0] r_flush_cnt;
    mode_e         r_mode;
    mode_e         r_mode_pend;
    mode_e         w_mode_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_err;

    logic          w_in_frame;
    logic          w_acc;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_pix;
    logic          w_interior;
    logic          w_restart;
    logic          w_err_evt;
    logic [PW-1:0] w_pipe_in;
    logic [PW-1:0] w_tap;

    // A frame start re-bases the position so a same-cycle pixel lands on (0,0).
    assign w_in_frame = (r_state == FILL) || (r_state == RUN);
    assign w_acc      = iPIX_VAL & (iFRAME_START | w_in_frame);
    assign w_col      = iFRAME_START ? '0 : r_col;
    assign w_row      = iFRAME_START ? '0 : r_row;
    assign w_last_col = (w_col == CW'(IMG_W - 1));
    assign w_last_pix = w_acc & w_last_col & (w_row == RW'(IMG_H - 1));
    assign w_interior = w_acc & (w_col >= CW'(2)) & (w_row >= RW'(2));
    assign w_restart  = iFRAME_START & (r_state != IDLE);
    assign w_err_evt  = w_restart | (iPIX_VAL & ~iFRAME_START & ~w_in_frame);

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a frame start always (re)enters FILL.
    always_comb begin
        w_next = r_state;
        if (iFRAME_START) begin
            w_next = FILL;
        end else begin
            case (r_state)
                IDLE:  w_next = IDLE;
                FILL:  w_next = (w_acc && (w_col == CW'(2)) && (w_row == RW'(2))) ? RUN : FILL;
                RUN:   w_next = w_last_pix ? FLUSH : RUN;
                FLUSH: w_next = (r_flush_cnt == FW'(LAT - 1)) ? IDLE : FLUSH;
                default: w_next = IDLE;
            endcase
        end
    end

    // Output decode: busy and the mode latched at an accepted frame start.
    always_comb begin
        w_busy_nxt = (w_next != IDLE);
        if (iFRAME_START) begin
            w_mode_nxt = iMODE_WR ? mode_e'(iMODE) : r_mode_pend;
        end else begin
            w_mode_nxt = r_mode;
        end
    end

    // Pixel position counters; the row never wraps, the last pixel ends the frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_last_pix) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_last_col) begin
                r_col <= '0;
                r_row <= w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end else if (iFRAME_START) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // Control and status registers.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_flush_cnt <= '0;
            r_mode_pend <= MODE_MAG;
            r_mode      <= MODE_MAG;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_flush_cnt <= ((r_state == FLUSH) && (w_next == FLUSH)) ? r_flush_cnt + FW'(1) : '0;
            r_mode_pend <= iMODE_WR ? mode_e'(iMODE) : r_mode_pend;
            r_mode      <= w_mode_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= r_err | w_err_evt;
        end
    end

    assign w_pipe_in = {w_interior, w_interior & w_last_col, w_interior & w_last_pix,
                        w_col - CW'(1), w_row - RW'(1)};

    win_delay_pipe #(
        .WIDTH (PW),
        .DEPTH (LAT)
    ) u_pipe (
        .i_clk   (iCLK),
        .i_rst_n (iRST),
        .i_flush (w_restart),
        .i_data  (w_pipe_in),
        .o_data  (w_tap)
    );

    // Done flags are qualified by valid so flushed windows cannot raise them.
    assign oWIN_VALID  = w_tap[PW-1];
    assign oLINE_DONE  = w_tap[PW-1] & w_tap[PW-2];
    assign oFRAME_DONE = w_tap[PW-1] & w_tap[PW-3];
    assign oX          = w_tap[RW +: CW];
    assign oY          = w_tap[RW-1:0];
    assign oMODE       = r_mode;
    assign oBUSY       = r_busy;
    assign oERR        = r_err;

endmodule
